char_row_fetch: RTL and testbench

Text-mode glyph fetcher and pixel serializer that sits directly downstream of the kernal ROM. It accepts character-row requests, reads the matching glyph word from the charset region of the ROM, and extracts one 8-pixel row. It then emits the row one pixel per cycle as 4-bit colour indices on a valid/ready stream toward the video output stage. Two row buffers hide the ROM latency, so back-to-back requests produce a gapless pixel stream.

---
 rtl/char_row_fetch_if.sv | 28 ++
 rtl/char_row_fetch.sv | 165 ++++++++++++++++
 tb/tb_char_row_fetch.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_row_fetch_if.sv
// Request / ROM / pixel-stream bundle for the glyph row fetcher.
// The slave modport is the fetcher itself; master is its environment.
interface char_row_fetch_if #(
   parameter int COLW = 4
);
   logic            req_valid;
   logic            req_ready;
   logic [6:0]      req_code;
   logic [2:0]      req_row;
   logic [COLW-1:0] req_fg;
   logic [COLW-1:0] req_bg;
   logic [11:0]     rom_addr;
   logic [31:0]     rom_data;
   logic            pix_valid;
   logic            pix_ready;
   logic [COLW-1:0] pix_data;
   logic            pix_last;

   modport slave (
      input  req_valid, req_code, req_row, req_fg, req_bg, rom_data, pix_ready,
      output req_ready, rom_addr, pix_valid, pix_data, pix_last
   );

   modport master (
      output req_valid, req_code, req_row, req_fg, req_bg, rom_data, pix_ready,
      input  req_ready, rom_addr, pix_valid, pix_data, pix_last
   );
endinterface

// File: rtl/char_row_fetch.sv
// Text-mode glyph fetcher: turns character-row requests into ROM reads,
// buffers the selected glyph byte in a 2-entry row FIFO and serializes it
// as one colour index per cycle on a valid/ready pixel stream.
module char_row_fetch #(
   parameter logic [11:0] CHARSET_BASE = 12'h400,
   parameter int          COLW         = 4
) (
   input logic              clk,
   input logic              rst,
   char_row_fetch_if.slave  bus
);

   typedef enum logic {S_EMPTY, S_SHIFT} ser_state_e;

   // Tag carried alongside the ROM read so the row can be built on return.
   typedef struct packed {
      logic [1:0]      sel;
      logic [COLW-1:0] fg;
      logic [COLW-1:0] bg;
   } tag_t;

   typedef struct packed {
      logic [7:0]      bits;
      logic [COLW-1:0] fg;
      logic [COLW-1:0] bg;
   } row_t;

   // Fetch pipeline
   logic        r_a_valid;
   logic        r_b_valid;
   tag_t        r_a_tag;
   tag_t        r_b_tag;
   logic [11:0] r_rom_addr;

   // Row FIFO
   row_t        r_fifo [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;

   // Serializer
   ser_state_e      r_state;
   logic [7:0]      r_bits;
   logic [COLW-1:0] r_fg;
   logic [COLW-1:0] r_bg;
   logic [2:0]      r_idx;
   logic            r_pix_valid;
   logic [COLW-1:0] r_pix_data;
   logic            r_pix_last;

   logic        w_accept;
   logic [2:0]  w_used;
   logic        w_req_ready;
   logic        w_wr;
   logic        w_pop;
   row_t        w_wr_row;
   row_t        w_head;

   // Credits cover FIFO entries plus reads still in the two fetch stages,
   // so every fetch in flight is guaranteed a FIFO slot on return.
   assign w_used      = {1'b0, r_count} + {2'b00, r_a_valid} + {2'b00, r_b_valid};
   assign w_req_ready = (w_used < 3'd2);
   assign w_accept    = bus.req_valid && w_req_ready;
   assign w_wr        = r_b_valid;
   assign w_head      = r_fifo[r_rd_ptr];

   // Pop when idle, or when the last pixel of the current row is taken.
   assign w_pop = (r_count != 2'd0) &&
                  ((r_state == S_EMPTY) ||
                   (bus.pix_ready && (r_idx == 3'd7)));

   // Pick the glyph byte for the requested row out of the returned word.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_wr_row    = '0;
      w_wr_row.fg = r_b_tag.fg;
      w_wr_row.bg = r_b_tag.bg;
      case (r_b_tag.sel)
         2'd0:    w_wr_row.bits = bus.rom_data[31:24];
         2'd1:    w_wr_row.bits = bus.rom_data[23:16];
         2'd2:    w_wr_row.bits = bus.rom_data[15:8];
         default: w_wr_row.bits = bus.rom_data[7:0];
      endcase
   end

   // Fetch pipeline: stage A drives the ROM address, stage B waits for data.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         r_a_valid  <= 1'b0;
         r_b_valid  <= 1'b0;
         r_a_tag    <= '0;
         r_b_tag    <= '0;
         r_rom_addr <= CHARSET_BASE;
      end else begin
         r_a_valid <= w_accept;
         r_b_valid <= r_a_valid;
         r_b_tag   <= r_a_tag;
         if (w_accept) begin
            r_rom_addr <= CHARSET_BASE | {4'h0, bus.req_code, bus.req_row[2]};
            r_a_tag    <= '{sel: bus.req_row[1:0], fg: bus.req_fg, bg: bus.req_bg};
         end
      end
   end

   // Row FIFO storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage is not reset; entries are only read after a pointer-guarded write.
      if (w_wr) r_fifo[r_wr_ptr] <= w_wr_row;
   end

   // Row FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_wr)  r_wr_ptr <= ~r_wr_ptr;
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
      end
   end

   // Serializer FSM with registered pixel outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_EMPTY;
         r_bits      <= '0;
         r_fg        <= '0;
         r_bg        <= '0;
         r_idx       <= 3'd0;
         r_pix_valid <= 1'b0;
         r_pix_data  <= '0;
         r_pix_last  <= 1'b0;
      end else if (w_pop) begin
         r_state     <= S_SHIFT;
         r_bits      <= w_head.bits;
         r_fg        <= w_head.fg;
         r_bg        <= w_head.bg;
         r_idx       <= 3'd0;
         r_pix_valid <= 1'b1;
         r_pix_data  <= w_head.bits[7] ? w_head.fg : w_head.bg;
         r_pix_last  <= 1'b0;
      end else if ((r_state == S_SHIFT) && bus.pix_ready) begin
         if (r_idx == 3'd7) begin
            r_state     <= S_EMPTY;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_last  <= 1'b0;
         end else begin
            r_idx      <= r_idx + 3'd1;
            r_pix_data <= r_bits[3'd6 - r_idx] ? r_fg : r_bg;
            r_pix_last <= (r_idx == 3'd6);
         end
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rom_addr  = r_rom_addr;
   assign bus.pix_valid = r_pix_valid;
   assign bus.pix_data  = r_pix_data;
   assign bus.pix_last  = r_pix_last;

endmodule

// File: tb/tb_char_row_fetch.sv
// Self-checking bench for char_row_fetch: directed scenarios plus a random
// phase, checked against a pixel-queue reference model and a ROM model.
module tb_char_row_fetch;

   logic clk;
   logic rst;

   char_row_fetch_if #(.COLW(4)) bus ();

   char_row_fetch #(.CHARSET_BASE(12'h400), .COLW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Kernal ROM model: registered read, data valid one cycle after address.
   logic [31:0] rom_mem [4096];
   always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

   typedef struct {
      logic [3:0] data;
      logic       last;
   } pix_t;

   pix_t        exp_q [$];
   int          checks;
   int          failures;
   int          pix_seen;
   logic        obs_pv;
   logic        accepted;
   logic        addr_pending;
   logic [11:0] addr_exp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rand_req();
      logic [31:0] r;
      r = $urandom;
      bus.req_code = r[6:0];
      bus.req_row  = r[9:7];
      bus.req_fg   = r[13:10];
      bus.req_bg   = r[17:14];
   endtask

   // Model of an accepted request: the 8 pixels it must produce, in order.
   task automatic model_push(input logic [6:0] code, input logic [2:0] row,
                             input logic [3:0] fg, input logic [3:0] bg);
      int          a;
      int          sel;
      logic [31:0] word;
      logic [7:0]  byte_v;
      pix_t        p;
      a      = 'h400 + int'(code) * 2 + int'(row) / 4;
      sel    = int'(row) % 4;
      word   = rom_mem[a];
      byte_v = 8'((word >> (8 * (3 - sel))) & 32'hFF);
      for (int i = 0; i < 8; i++) begin
         p.data = byte_v[7 - i] ? fg : bg;
         p.last = (i == 7);
         exp_q.push_back(p);
      end
      addr_exp     = 12'(a);
      addr_pending = 1'b1;
   endtask

   // Sample on the falling edge; handshakes complete on the following rising edge.
   task automatic observe();
      int rows_left;
      int pending;
      rows_left = (exp_q.size() + 7) / 8;
      pending   = rows_left - (bus.pix_valid ? 1 : 0);
      check("req_ready_credit", {31'd0, bus.req_ready}, {31'd0, (pending < 2)});
      if (addr_pending) begin
         check("rom_addr", {20'd0, bus.rom_addr}, {20'd0, addr_exp});
         addr_pending = 1'b0;
      end
      if (exp_q.size() == 0) begin
         check("stray_pixel", {31'd0, bus.pix_valid}, 32'd0);
      end else if (bus.pix_valid && bus.pix_ready) begin
         check("pix_data", {28'd0, bus.pix_data}, {28'd0, exp_q[0].data});
         check("pix_last", {31'd0, bus.pix_last}, {31'd0, exp_q[0].last});
         void'(exp_q.pop_front());
         pix_seen++;
      end
      accepted = 1'b0;
      if (bus.req_valid && bus.req_ready) begin
         accepted = 1'b1;
         model_push(bus.req_code, bus.req_row, bus.req_fg, bus.req_bg);
      end
      obs_pv = bus.pix_valid;
   endtask

   task automatic step();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      bus.req_valid = 1'b0;
      bus.pix_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int base;
      int sent;
      int acc;
      bit started;

      checks       = 0;
      failures     = 0;
      pix_seen     = 0;
      obs_pv       = 1'b0;
      accepted     = 1'b0;
      addr_pending = 1'b0;
      addr_exp     = '0;
      for (int i = 0; i < 4096; i++) rom_mem[i] = $urandom;
      rom_mem['h483] = 32'h00A5_0000;
      rom_mem['h4FF] = 32'h5A3C_96C5;
      rom_mem['h400] = 32'hB400_FF00;

      rst           = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_code  = '0;
      bus.req_row   = '0;
      bus.req_fg    = '0;
      bus.req_bg    = '0;
      bus.pix_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_pix_valid", {31'd0, bus.pix_valid}, 32'd0);
      check("rst_pix_data",  {28'd0, bus.pix_data},  32'd0);
      check("rst_pix_last",  {31'd0, bus.pix_last},  32'd0);
      check("rst_rom_addr",  {20'd0, bus.rom_addr},  32'h400);
      rst = 1'b1;
      step();

      // Basic row: code 0x41 row 5 -> word 0x483, byte 0xA5
      bus.pix_ready = 1'b1;
      bus.req_code  = 7'h41;
      bus.req_row   = 3'd5;
      bus.req_fg    = 4'hF;
      bus.req_bg    = 4'h2;
      bus.req_valid = 1'b1;
      step();
      check("basic_accept", {31'd0, accepted}, 32'd1);
      bus.req_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("basic_latency", {31'd0, obs_pv}, {31'd0, (k == 4)});
      end
      drain("basic_drained", 20);

      // Back-to-back: 4 requests as fast as credit allows, gapless output
      base    = pix_seen;
      sent    = 0;
      started = 1'b0;
      rand_req();
      bus.req_valid = 1'b1;
      for (int c = 0; c < 80; c++) begin
         step();
         if (accepted) begin
            sent++;
            if (sent == 4) bus.req_valid = 1'b0;
            else rand_req();
         end
         if (started && (pix_seen - base < 32))
            check("b2b_gap", {31'd0, obs_pv}, 32'd1);
         if (obs_pv) started = 1'b1;
         if (sent == 4 && exp_q.size() == 0) break;
      end
      check("b2b_sent", 32'(sent), 32'd4);
      check("b2b_pixels", 32'(pix_seen - base), 32'd32);
      drain("b2b_drained", 10);

      // Backpressure at idx 3 for 20 cycles
      base = pix_seen;
      rand_req();
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (pix_seen - base == 3) break;
      end
      check("bp_reached_idx3", 32'(pix_seen - base), 32'd3);
      bus.pix_ready = 1'b0;
      acc = 0;
      rand_req();
      bus.req_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         check("bp_hold_valid", {31'd0, obs_pv}, 32'd1);
         check("bp_hold_data", {28'd0, bus.pix_data}, {28'd0, exp_q[0].data});
         check("bp_hold_last", {31'd0, bus.pix_last}, {31'd0, exp_q[0].last});
         if (accepted) begin
            acc++;
            if (acc == 2) bus.req_valid = 1'b0;
            else rand_req();
         end
      end
      check("bp_accepts", 32'(acc), 32'd2);
      check("bp_ready_low", {31'd0, bus.req_ready}, 32'd0);
      check("bp_queue", 32'(exp_q.size()), 32'd21);
      drain("bp_drained", 60);

      // Byte select and code wrap
      bus.req_code  = 7'h7F;
      bus.req_row   = 3'd7;
      bus.req_fg    = 4'h9;
      bus.req_bg    = 4'h6;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      check("wrap_rom_addr", {20'd0, bus.rom_addr}, 32'h4FF);
      drain("wrap_drained", 20);
      bus.req_code  = 7'h00;
      bus.req_row   = 3'd0;
      bus.req_fg    = 4'h3;
      bus.req_bg    = 4'hC;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      check("zero_rom_addr", {20'd0, bus.rom_addr}, 32'h400);
      drain("zero_drained", 20);

      // Reset while one row shifts and one fetch is in flight
      rand_req();
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (obs_pv) break;
         step();
      end
      check("rst_mid_shifting", {31'd0, obs_pv}, 32'd1);
      rand_req();
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      check("rst_mid_inflight", {31'd0, accepted}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_pix_valid", {31'd0, bus.pix_valid}, 32'd0);
      check("arst_pix_data",  {28'd0, bus.pix_data},  32'd0);
      check("arst_pix_last",  {31'd0, bus.pix_last},  32'd0);
      check("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("arst_rom_addr",  {20'd0, bus.rom_addr},  32'h400);
      exp_q.delete();
      addr_pending = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      for (int c = 0; c < 12; c++) step();
      check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

      // Random traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         rand_req();
         bus.req_valid = ($urandom % 2) == 0;
         bus.pix_ready = ($urandom % 4) != 0;
         step();
      end
      drain("rand_drained", 120);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
